// File: rtl/serial_subtractor_8bit_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  // Requester side: issues operands and start, watches status and results.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, overflow
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, overflow
  );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one bit per clock, with borrow-out and signed-overflow flags.
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_8bit_if.slave  sub
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, diff_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg, msb_bin_reg;
  logic             busy_reg, done_reg, bout_reg, ovf_reg;

  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // Per-bit full-subtractor slice and FSM next-state decode.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    d_bit      = a_reg[0] ^ b_reg[0] ^ br_reg;
    br_next    = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
    res_shift  = {d_bit, res_reg[WIDTH-1:1]};
    last_bit   = (cnt_reg == CW'(WIDTH - 1));
    case (state_reg)
      IDLE: begin
        if (sub.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        // A start in the completion cycle chains straight into the next op.
        if (sub.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Operand shifting, result assembly and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      diff_reg    <= '0;
      cnt_reg     <= '0;
      br_reg      <= 1'b0;
      msb_bin_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      bout_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_reg       <= sub.a;
        b_reg       <= sub.b;
        br_reg      <= sub.bin;
        res_reg     <= '0;
        cnt_reg     <= '0;
        msb_bin_reg <= 1'b0;
        busy_reg    <= 1'b1;
      end else if (state_reg == RUN) begin
        a_reg   <= a_reg >> 1;
        b_reg   <= b_reg >> 1;
        br_reg  <= br_next;
        res_reg <= res_shift;
        cnt_reg <= cnt_reg + CW'(1);
        // Borrow entering the sign bit, needed for signed overflow.
        if (cnt_reg == CW'(WIDTH - 2)) msb_bin_reg <= br_next;
        if (last_bit) begin
          diff_reg <= res_shift;
          bout_reg <= br_next;
          ovf_reg  <= msb_bin_reg ^ br_next;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
      end
    end
  end

  assign sub.busy     = busy_reg;
  assign sub.done     = done_reg;
  assign sub.diff     = diff_reg;
  assign sub.bout     = bout_reg;
  assign sub.overflow = ovf_reg;
endmodule
